// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the UART receiver / APB register file (master side) and the
// receive controller (slave side).
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                  baud_en_16x;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_ready;
  logic                  rx_busy;
  logic                  rx_error;
  logic                  rx_en;
  logic                  flush;
  logic                  clr_err;
  logic                  irq_en;
  logic [LW-1:0]         irq_thresh;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_perr;
  logic [LW-1:0]         rx_level;
  logic                  rx_empty;
  logic                  rx_full;
  logic                  overrun_err;
  logic                  frame_err;
  logic                  timeout;
  logic                  irq;

  modport master (
    output baud_en_16x, rx_data, rx_ready, rx_busy, rx_error, rx_en, flush,
           clr_err, irq_en, irq_thresh, rd_en,
    input  rd_data, rd_perr, rx_level, rx_empty, rx_full, overrun_err,
           frame_err, timeout, irq
  );

  modport slave (
    input  baud_en_16x, rx_data, rx_ready, rx_busy, rx_error, rx_en, flush,
           clr_err, irq_en, irq_thresh, rd_en,
    output rd_data, rd_perr, rx_level, rx_empty, rx_full, overrun_err,
           frame_err, timeout, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: character FIFO with parity flags, overrun /
// framing / timeout detection and a single registered interrupt.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int TIMEOUT_TICKS = 704
) (
  input logic            clk,
  input logic            rst_n,
  uart_rx_ctrl_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);

  typedef struct packed {
    logic                  perr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;
  logic          overrun_q, overrun_d;
  logic          frame_q, frame_d;
  logic          timeout_q, timeout_d;
  logic          irq_q, irq_d;

  logic is_empty, is_full;
  logic push_req, do_push, do_pop;
  logic overrun_set, frame_set, timeout_set, cnt_clr, level_hit;

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == LW'(FIFO_DEPTH));

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign push_req    = bus.rx_ready & bus.rx_en;
  assign do_pop      = bus.rd_en & ~is_empty;
  assign do_push     = push_req & (~is_full | do_pop);
  assign overrun_set = push_req & ~do_push;
  assign frame_set   = bus.rx_en & busy_q & ~bus.rx_busy & bus.rx_error & ~bus.rx_ready;

  assign cnt_clr     = do_push | do_pop | bus.flush | bus.rx_busy | is_empty;
  assign timeout_set = ~cnt_clr & bus.baud_en_16x & (cnt_q == CW'(TIMEOUT_TICKS - 1));
  assign level_hit   = (bus.irq_thresh != '0) && (level_q >= bus.irq_thresh);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    frame_d   = frame_q;
    timeout_d = timeout_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    if (cnt_clr)
      cnt_d = '0;
    else if (bus.baud_en_16x && cnt_q != CW'(TIMEOUT_TICKS))
      cnt_d = cnt_q + CW'(1);

    // Set events take priority over clearing in the same cycle.
    if (bus.clr_err) begin
      overrun_d = 1'b0;
      frame_d   = 1'b0;
    end
    if (overrun_set) overrun_d = 1'b1;
    if (frame_set)   frame_d   = 1'b1;

    if (bus.clr_err || do_pop || bus.flush) timeout_d = 1'b0;
    if (timeout_set)                        timeout_d = 1'b1;

    irq_d = bus.irq_en & (level_hit | timeout_q | overrun_q | frame_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
      timeout_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      busy_q    <= bus.rx_busy;
      overrun_q <= overrun_d;
      frame_q   <= frame_d;
      timeout_q <= timeout_d;
      irq_q     <= irq_d;
    end
  end

  // NOTE: storage is not reset; the read port masks it to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= '{perr: bus.rx_error, data: bus.rx_data};
  end

  assign bus.rd_data     = is_empty ? '0   : mem_q[rd_ptr_q].data;
  assign bus.rd_perr     = is_empty ? 1'b0 : mem_q[rd_ptr_q].perr;
  assign bus.rx_level    = level_q;
  assign bus.rx_empty    = is_empty;
  assign bus.rx_full     = is_full;
  assign bus.overrun_err = overrun_q;
  assign bus.frame_err   = frame_q;
  assign bus.timeout     = timeout_q;
  assign bus.irq         = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: FIFO ordering, overrun, framing, irq level
// threshold, character timeout and asynchronous reset.
module tb_uart_rx_ctrl;
  localparam int DW = 8;
  localparam int FD = 16;
  localparam int TT = 704;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  uart_rx_ctrl_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .TIMEOUT_TICKS(TT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    bus.rx_data  = d;
    bus.rx_error = e;
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
    bus.rx_error = 1'b0;
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.rx_level !== 5'd0 || bus.rx_empty !== 1'b1 || bus.rx_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_level: level=%0d empty=%b full=%b, want 0/1/0", bus.rx_level, bus.rx_empty, bus.rx_full);
    end
    vectors++;
    if (bus.rd_data !== 8'h00 || bus.rd_perr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_head: data=%h perr=%b, want 00/0", bus.rd_data, bus.rd_perr);
    end
    vectors++;
    if ({bus.overrun_err, bus.frame_err, bus.timeout, bus.irq} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: ovr/frm/tmo/irq=%b, want 0000", {bus.overrun_err, bus.frame_err, bus.timeout, bus.irq});
    end
  endtask

  task automatic test_basic();
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b1);
    vectors++;
    if (bus.rx_level !== 5'd2 || bus.rd_data !== 8'hA5 || bus.rd_perr !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_head0: level=%0d data=%h perr=%b, want 2/a5/0", bus.rx_level, bus.rd_data, bus.rd_perr);
    end
    pop();
    vectors++;
    if (bus.rx_level !== 5'd1 || bus.rd_data !== 8'h3C || bus.rd_perr !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_head1: level=%0d data=%h perr=%b, want 1/3c/1", bus.rx_level, bus.rd_data, bus.rd_perr);
    end
    pop();
    vectors++;
    if (bus.rx_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_empty: empty=%b, want 1", bus.rx_empty);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < FD; i++) push(8'h10 + 8'(i), 1'b0);
    vectors++;
    if (bus.rx_full !== 1'b1 || bus.overrun_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_full16: full=%b ovr=%b, want 1/0", bus.rx_full, bus.overrun_err);
    end
    push(8'hEE, 1'b0);
    vectors++;
    if (bus.rx_level !== 5'd16 || bus.overrun_err !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_set: level=%0d ovr=%b, want 16/1", bus.rx_level, bus.overrun_err);
    end
    for (int i = 0; i < FD; i++) begin
      vectors++;
      if (bus.rd_data !== 8'h10 + 8'(i)) begin
        miscompares++;
        $display("FAIL ovr_order[%0d]: data=%h, want %h", i, bus.rd_data, 8'h10 + 8'(i));
      end
      pop();
    end
    vectors++;
    if (bus.rx_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_drain: empty=%b, want 1", bus.rx_empty);
    end
    pop();
    vectors++;
    if (bus.rx_level !== 5'd0) begin
      miscompares++;
      $display("FAIL pop_empty: level=%0d, want 0", bus.rx_level);
    end
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    vectors++;
    if (bus.overrun_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_clr: ovr=%b, want 0", bus.overrun_err);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < FD; i++) push(8'h40 + 8'(i), 1'b0);
    bus.rd_en = 1'b1;
    push(8'h77, 1'b0);
    bus.rd_en = 1'b0;
    vectors++;
    if (bus.rx_level !== 5'd16 || bus.overrun_err !== 1'b0) begin
      miscompares++;
      $display("FAIL fpp_level: level=%0d ovr=%b, want 16/0", bus.rx_level, bus.overrun_err);
    end
    for (int i = 1; i <= FD; i++) begin
      logic [7:0] exp;
      exp = (i == FD) ? 8'h77 : 8'h40 + 8'(i);
      vectors++;
      if (bus.rd_data !== exp) begin
        miscompares++;
        $display("FAIL fpp_order[%0d]: data=%h, want %h", i, bus.rd_data, exp);
      end
      pop();
    end
  endtask

  task automatic test_frame();
    push(8'h55, 1'b0);
    bus.rx_busy = 1'b1; step();
    bus.rx_busy = 1'b0; bus.rx_error = 1'b1; step();
    bus.rx_error = 1'b0;
    vectors++;
    if (bus.frame_err !== 1'b1 || bus.rx_level !== 5'd1) begin
      miscompares++;
      $display("FAIL frame_set: frm=%b level=%0d, want 1/1", bus.frame_err, bus.rx_level);
    end
    bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
    vectors++;
    if (bus.frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_clr: frm=%b, want 0", bus.frame_err);
    end
    bus.rx_busy = 1'b1; step();
    bus.rx_busy = 1'b0; step();
    vectors++;
    if (bus.frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL false_start: frm=%b, want 0", bus.frame_err);
    end
    bus.rx_busy = 1'b1; step();
    bus.rx_busy = 1'b0; bus.rx_error = 1'b1; bus.clr_err = 1'b1; step();
    bus.rx_error = 1'b0; bus.clr_err = 1'b0;
    vectors++;
    if (bus.frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_vs_clr: frm=%b, want 1", bus.frame_err);
    end
    bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
    bus.rx_en = 1'b0;
    push(8'h99, 1'b0);
    bus.rx_busy = 1'b1; step();
    bus.rx_busy = 1'b0; bus.rx_error = 1'b1; step();
    bus.rx_error = 1'b0;
    vectors++;
    if (bus.rx_level !== 5'd1 || bus.frame_err !== 1'b0 || bus.overrun_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_dis: level=%0d frm=%b ovr=%b, want 1/0/0", bus.rx_level, bus.frame_err, bus.overrun_err);
    end
    bus.rx_en = 1'b1;
    bus.flush = 1'b1;
    push(8'h12, 1'b0);
    bus.flush = 1'b0;
    vectors++;
    if (bus.rx_level !== 5'd0 || bus.rx_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_push: level=%0d empty=%b, want 0/1", bus.rx_level, bus.rx_empty);
    end
  endtask

  task automatic test_irq_level();
    bus.irq_en = 1'b1;
    bus.irq_thresh = 5'd4;
    for (int i = 1; i <= 3; i++) begin
      push(8'(i), 1'b0);
      step();
      vectors++;
      if (bus.irq !== 1'b0) begin
        miscompares++;
        $display("FAIL irq_below[%0d]: irq=%b, want 0", i, bus.irq);
      end
    end
    push(8'h04, 1'b0);
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_latency: irq=%b, want 0", bus.irq);
    end
    step();
    vectors++;
    if (bus.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_level: irq=%b, want 1", bus.irq);
    end
    pop();
    vectors++;
    if (bus.rx_level !== 5'd3 || bus.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_pop0: level=%0d irq=%b, want 3/1", bus.rx_level, bus.irq);
    end
    step();
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_pop1: irq=%b, want 0", bus.irq);
    end
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    bus.irq_thresh = 5'd0;
  endtask

  task automatic test_timeout();
    push(8'h61, 1'b0);
    bus.baud_en_16x = 1'b1;
    repeat (TT - 1) step();
    vectors++;
    if (bus.timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_early: tmo=%b, want 0", bus.timeout);
    end
    step();
    vectors++;
    if (bus.timeout !== 1'b1 || bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_set: tmo=%b irq=%b, want 1/0", bus.timeout, bus.irq);
    end
    step();
    vectors++;
    if (bus.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_irq: irq=%b, want 1", bus.irq);
    end
    bus.baud_en_16x = 1'b0;
    pop();
    vectors++;
    if (bus.timeout !== 1'b0 || bus.rx_level !== 5'd0) begin
      miscompares++;
      $display("FAIL tmo_pop: tmo=%b level=%0d, want 0/0", bus.timeout, bus.rx_level);
    end
    push(8'h62, 1'b0);
    bus.baud_en_16x = 1'b1;
    repeat (700) step();
    bus.rx_busy = 1'b1; step();
    bus.rx_busy = 1'b0;
    repeat (TT - 1) step();
    vectors++;
    if (bus.timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_restart: tmo=%b, want 0", bus.timeout);
    end
    step();
    vectors++;
    if (bus.timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_reset_set: tmo=%b, want 1", bus.timeout);
    end
    bus.baud_en_16x = 1'b0;
    pop();
  endtask

  task automatic test_async_reset();
    bus.irq_en = 1'b1;
    bus.irq_thresh = 5'd1;
    push(8'h81, 1'b1);
    push(8'h82, 1'b0);
    step();
    vectors++;
    if (bus.irq !== 1'b1 || bus.rx_level !== 5'd2) begin
      miscompares++;
      $display("FAIL arst_pre: irq=%b level=%0d, want 1/2", bus.irq, bus.rx_level);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.rx_level !== 5'd0 || bus.rx_empty !== 1'b1 || bus.rd_data !== 8'h00 ||
        bus.rd_perr !== 1'b0 || bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_now: level=%0d empty=%b data=%h perr=%b irq=%b, want 0/1/00/0/0",
               bus.rx_level, bus.rx_empty, bus.rd_data, bus.rd_perr, bus.irq);
    end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.baud_en_16x = 1'b0;
    bus.rx_data     = '0;
    bus.rx_ready    = 1'b0;
    bus.rx_busy     = 1'b0;
    bus.rx_error    = 1'b0;
    bus.rx_en       = 1'b1;
    bus.flush       = 1'b0;
    bus.clr_err     = 1'b0;
    bus.irq_en      = 1'b0;
    bus.irq_thresh  = '0;
    bus.rd_en       = 1'b0;
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_basic();
    test_overrun();
    test_full_push_pop();
    test_frame();
    test_irq_level();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
